// File: rtl/len_keep_tx_pkg.sv
// ---------------------------------------------------------------------------
// len_keep_tx_pkg
// Shared definitions for the transmit-side length-to-keep segmenter.
//   state_t  : segmenter FSM states (IDLE waits for a length, STREAM emits beats)
//   TX_D_W   : default bytes per data beat on the MoldUDP64 tx path
//   TX_LEN_W : default width of the message length field in bytes
// ---------------------------------------------------------------------------
package len_keep_tx_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   localparam int TX_D_W   = 8;
   localparam int TX_LEN_W = 16;

endpackage

// File: rtl/len_keep_tx_thermo_from_cnt.sv
// ---------------------------------------------------------------------------
// thermo_from_cnt
// Combinational byte count to thermometer mask: mask_o = (1 << cnt_i) - 1.
// A count of D_W yields all ones.
// Ports:
//   cnt_i  [D_LW-1:0]  number of valid bytes, 0..D_W
//   mask_o [D_W-1:0]   thermometer mask, bit i set when i < cnt_i
// ---------------------------------------------------------------------------
module thermo_from_cnt
   import len_keep_tx_pkg::*;
#(
   parameter int D_W  = TX_D_W,
   parameter int D_LW = $clog2(D_W) + 1
) (
   input  logic [D_LW-1:0] cnt_i,
   output logic [D_W-1:0]  mask_o
);

   localparam int MW = D_W + 1;

   logic [D_W-1:0] mask;

   // Build the mask one bit at a time by comparing each byte lane index
   // against the count. The checks sit in the same block as the mask so they
   // always see a mask and a count that belong together: the mask must hold
   // exactly cnt_i ones, and adding one to it must give a single set bit,
   // which is only true for a contiguous run starting at bit 0.
   always_comb begin
      mask = '0;
      for (int i = 0; i < D_W; i++) begin
         mask[i] = (D_LW'(i) < cnt_i);
      end
      mask_o = mask;
      if (cnt_i <= D_LW'(D_W)) begin
         assert ($countones(mask) == int'(cnt_i));
         assert ($onehot({1'b0, mask} + MW'(1)));
      end
   end

endmodule

// File: rtl/len_keep_tx.sv
// ---------------------------------------------------------------------------
// len_keep_tx
// Transmit-side segmenter. Accepts a message length in bytes, then slices the
// following stream of D_W-byte words into beats carrying a thermometer keep
// mask and a last flag. One output register, one cycle latency, full rate.
// Ports:
//   clk, nreset                 clock, synchronous active-low reset
//   cmd_valid_i/cmd_len_i       message length command
//   cmd_ready_o                 command accepted (IDLE only)
//   data_valid_i/data_i         input data word, byte 0 in bits [7:0]
//   data_ready_o                input word accepted (STREAM, output free)
//   valid_o/data_o/keep_o/last_o output beat
//   ready_i                     downstream ready
// ---------------------------------------------------------------------------
module len_keep_tx
   import len_keep_tx_pkg::*;
#(
   parameter int D_W   = TX_D_W,
   parameter int LEN_W = TX_LEN_W,
   parameter int D_LW  = $clog2(D_W) + 1
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             cmd_valid_i,
   input  logic [LEN_W-1:0] cmd_len_i,
   output logic             cmd_ready_o,
   input  logic             data_valid_i,
   input  logic [8*D_W-1:0] data_i,
   output logic             data_ready_o,
   output logic             valid_o,
   output logic [8*D_W-1:0] data_o,
   output logic [D_W-1:0]   keep_o,
   output logic             last_o,
   input  logic             ready_i
);

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic               valid_q, valid_d;
   logic [8*D_W-1:0]   data_q, data_d;
   logic [D_W-1:0]     keep_q, keep_d;
   logic               last_q, last_d;

   logic               cmdFire;
   logic               dataFire;
   logic               drainFire;
   logic               remGeDw;
   logic               remLeDw;
   logic [D_LW-1:0]    thermoCnt;
   logic [D_W-1:0]     thermoMask;

   // Handshakes. Both ready outputs are forced low while reset is held so
   // nothing upstream is consumed during a reset cycle. A word is taken
   // whenever the output register is empty or is being drained this cycle,
   // which gives back-to-back beats with no bubble.
   always_comb begin
      cmd_ready_o  = nreset & (state_q == IDLE);
      data_ready_o = nreset & (state_q == STREAM) & (~valid_q | ready_i);
      cmdFire      = cmd_valid_i & cmd_ready_o;
      dataFire     = data_valid_i & data_ready_o;
      drainFire    = valid_q & ready_i;
   end

   // Byte count for the beat being loaded. Comparisons are made on the full
   // remaining length; only when fewer than D_W bytes remain do the low bits
   // of rem carry the partial count, otherwise a full D_W count is fed in.
   always_comb begin
      remGeDw   = (rem_q >= LEN_W'(D_W));
      remLeDw   = (rem_q <= LEN_W'(D_W));
      thermoCnt = remGeDw ? D_LW'(D_W) : rem_q[D_LW-1:0];
   end

   thermo_from_cnt #(
      .D_W  (D_W),
      .D_LW (D_LW)
   ) uThermo (
      .cnt_i  (thermoCnt),
      .mask_o (thermoMask)
   );

   // Next-state logic for the FSM and the remaining-byte counter. A zero
   // length command is swallowed in IDLE without producing a beat. In STREAM
   // every accepted word takes up to D_W bytes off the count, saturating at
   // zero, and the word that covers the tail of the message returns to IDLE.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: begin
            if (cmdFire && (cmd_len_i != '0)) begin
               rem_d   = cmd_len_i;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (dataFire) begin
               rem_d = remGeDw ? (rem_q - LEN_W'(D_W)) : '0;
               if (remLeDw) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output register. A new word always wins over a plain drain, so a drain
   // and a load in the same cycle just replace the beat. Without a load the
   // beat is held until the downstream takes it, after which only valid
   // drops; the data fields keep their last values.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      if (dataFire) begin
         valid_d = 1'b1;
         data_d  = data_i;
         keep_d  = thermoMask;
         last_d  = remLeDw;
      end else if (drainFire) begin
         valid_d = 1'b0;
      end
   end

   // State register with synchronous reset. Reset drops any message in
   // flight; the upstream has to send the command again.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign keep_o  = keep_q;
   assign last_o  = last_q;

endmodule

// File: tb/tb_len_keep_tx.sv
// ---------------------------------------------------------------------------
// tb_len_keep_tx
// Bench for len_keep_tx with D_W=8, LEN_W=16. A reference model turns each
// accepted length into the list of beats it must produce (byte count per
// beat, keep mask, last flag); accepted data words are queued and must come
// out in order. Directed sequences cover the corner cases and a table of
// lengths checks beat counts and edge masks against fixed values.
// ---------------------------------------------------------------------------
module tb_len_keep_tx;

   typedef struct {
      logic [7:0] keep;
      logic       last;
   } beat_t;

   typedef struct {
      logic [15:0] len;
      int          beats;
      logic [7:0]  firstKeep;
      logic [7:0]  lastKeep;
   } vec_t;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic [15:0] cmd_len_i = '0;
   logic        cmd_ready_o;
   logic        data_valid_i = 1'b0;
   logic [63:0] data_i = '0;
   logic        data_ready_o;
   logic        valid_o;
   logic [63:0] data_o;
   logic [7:0]  keep_o;
   logic        last_o;
   logic        ready_i = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [15:0] cmdQ[$];
   logic [63:0] srcDataQ[$];
   beat_t       expBeatQ[$];
   logic [63:0] expDataQ[$];
   logic [7:0]  keepSeenQ[$];
   logic        lastSeenQ[$];
   int          outCycQ[$];

   int   readyMode = 0;
   int   validMode = 0;
   int   cycleCount = 0;
   int   cmdFireCount = 0;
   int   dataFireCount = 0;
   logic cmdFirePending = 1'b0;

   logic        prevStall = 1'b0;
   logic        prevValid, prevLast;
   logic [63:0] prevData;
   logic [7:0]  prevKeep;

   vec_t vecs[8];

   len_keep_tx #(
      .D_W   (8),
      .LEN_W (16),
      .D_LW  (4)
   ) dut (
      .clk          (clk),
      .nreset       (nreset),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_len_i    (cmd_len_i),
      .cmd_ready_o  (cmd_ready_o),
      .data_valid_i (data_valid_i),
      .data_i       (data_i),
      .data_ready_o (data_ready_o),
      .valid_o      (valid_o),
      .data_o       (data_o),
      .keep_o       (keep_o),
      .last_o       (last_o),
      .ready_i      (ready_i)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Hard stop in case the bench itself gets stuck somewhere.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: a message of len bytes is ceil(len/8) beats, each
   // carrying min(8, bytes left) bytes, the final one flagged last.
   task automatic modelCommand(input logic [15:0] len);
      int    nb;
      int    bytes;
      beat_t b;
      nb = (int'(len) + 7) / 8;
      for (int k = 0; k < nb; k++) begin
         bytes  = int'(len) - 8 * k;
         if (bytes > 8) bytes = 8;
         b.keep = 8'((16'd1 << bytes) - 16'd1);
         b.last = (k == nb - 1);
         expBeatQ.push_back(b);
      end
   endtask

   task automatic queueMessage(input logic [15:0] len);
      cmdQ.push_back(len);
      for (int k = 0; k < (int'(len) + 7) / 8; k++) begin
         srcDataQ.push_back({$urandom, $urandom});
      end
   endtask

   task automatic startTest();
      keepSeenQ.delete();
      lastSeenQ.delete();
      outCycQ.delete();
      cmdFireCount  = 0;
      dataFireCount = 0;
   endtask

   // One clock cycle: drive inputs after the falling edge, then sample the
   // DUT a little later, well away from the rising edge, and score every
   // handshake that will happen at the coming rising edge.
   task automatic applyStimulus();
      beat_t eb;
      @(negedge clk);
      cycleCount++;
      if (cmdQ.size() > 0 && (validMode == 0 || $urandom_range(0, 3) != 0)) begin
         cmd_valid_i = 1'b1;
         cmd_len_i   = cmdQ[0];
      end else begin
         cmd_valid_i = 1'b0;
         cmd_len_i   = 16'($urandom);
      end
      if (srcDataQ.size() > 0 && (validMode == 0 || $urandom_range(0, 3) != 0)) begin
         data_valid_i = 1'b1;
         data_i       = srcDataQ[0];
      end else begin
         data_valid_i = 1'b0;
         data_i       = {$urandom, $urandom};
      end
      case (readyMode)
         0:       ready_i = 1'b1;
         1:       ready_i = ~ready_i;
         default: ready_i = ($urandom_range(0, 2) != 0);
      endcase
      #1;
      if (prevStall) begin
         checkOutput("hold_valid", 64'(valid_o), 64'(prevValid));
         checkOutput("hold_data", data_o, prevData);
         checkOutput("hold_keep", 64'(keep_o), 64'(prevKeep));
         checkOutput("hold_last", 64'(last_o), 64'(prevLast));
      end
      if (valid_o && !ready_i) begin
         checkOutput("stall_data_ready", 64'(data_ready_o), 64'd0);
      end
      if (cmd_valid_i && cmd_ready_o) begin
         cmdFireCount++;
         cmdFirePending = valid_o;
         modelCommand(cmdQ.pop_front());
      end
      if (valid_o && ready_i) begin
         if (expBeatQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat: got keep 0x%0h last %0b, expected no beat", keep_o, last_o);
         end else begin
            eb = expBeatQ.pop_front();
            checkOutput("beat_keep", 64'(keep_o), 64'(eb.keep));
            checkOutput("beat_last", 64'(last_o), 64'(eb.last));
         end
         if (expDataQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_data: got 0x%0h, expected no data word", data_o);
         end else begin
            checkOutput("beat_data", data_o, expDataQ.pop_front());
         end
         keepSeenQ.push_back(keep_o);
         lastSeenQ.push_back(last_o);
         outCycQ.push_back(cycleCount);
      end
      if (data_valid_i && data_ready_o) begin
         dataFireCount++;
         expDataQ.push_back(srcDataQ.pop_front());
      end
      prevStall = valid_o && !ready_i;
      prevValid = valid_o;
      prevData  = data_o;
      prevKeep  = keep_o;
      prevLast  = last_o;
   endtask

   // Run until everything queued has been consumed and emitted.
   task automatic drain(input int budget);
      int n = 0;
      while ((cmdQ.size() > 0 || srcDataQ.size() > 0 || expBeatQ.size() > 0 || valid_o) && n < budget) begin
         applyStimulus();
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: got %0d beats pending, expected 0", expBeatQ.size());
      end
      checkOutput("data_leftover", 64'(expDataQ.size()), 64'd0);
   endtask

   task automatic checkSeen(input string name, input int idx, input logic [7:0] keep, input logic last);
      if (idx < keepSeenQ.size()) begin
         checkOutput({name, "_keep"}, 64'(keepSeenQ[idx]), 64'(keep));
         checkOutput({name, "_last"}, 64'(lastSeenQ[idx]), 64'(last));
      end
   endtask

   initial begin
      int n;

      vecs[0] = '{len: 16'd16, beats: 2, firstKeep: 8'hFF, lastKeep: 8'hFF};
      vecs[1] = '{len: 16'd13, beats: 2, firstKeep: 8'hFF, lastKeep: 8'h1F};
      vecs[2] = '{len: 16'd1,  beats: 1, firstKeep: 8'h01, lastKeep: 8'h01};
      vecs[3] = '{len: 16'd8,  beats: 1, firstKeep: 8'hFF, lastKeep: 8'hFF};
      vecs[4] = '{len: 16'd20, beats: 3, firstKeep: 8'hFF, lastKeep: 8'h0F};
      vecs[5] = '{len: 16'd9,  beats: 2, firstKeep: 8'hFF, lastKeep: 8'h01};
      vecs[6] = '{len: 16'd7,  beats: 1, firstKeep: 8'h7F, lastKeep: 8'h7F};
      vecs[7] = '{len: 16'd0,  beats: 0, firstKeep: 8'h00, lastKeep: 8'h00};

      // Reset: ready outputs must be low while reset is held and the
      // output register must come up cleared.
      nreset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput("reset_cmd_ready", 64'(cmd_ready_o), 64'd0);
         checkOutput("reset_data_ready", 64'(data_ready_o), 64'd0);
      end
      checkOutput("reset_valid", 64'(valid_o), 64'd0);
      checkOutput("reset_data", data_o, 64'd0);
      checkOutput("reset_keep", 64'(keep_o), 64'd0);
      checkOutput("reset_last", 64'(last_o), 64'd0);
      nreset = 1'b1;
      applyStimulus();
      checkOutput("idle_cmd_ready", 64'(cmd_ready_o), 64'd1);

      // Table of lengths with fixed expected beat counts and edge masks.
      readyMode = 0;
      validMode = 0;
      for (int i = 0; i < 8; i++) begin
         startTest();
         queueMessage(vecs[i].len);
         drain(100);
         checkOutput($sformatf("vec%0d_beats", i), 64'(keepSeenQ.size()), 64'(vecs[i].beats));
         if (vecs[i].beats > 0 && keepSeenQ.size() > 0) begin
            checkOutput($sformatf("vec%0d_first_keep", i), 64'(keepSeenQ[0]), 64'(vecs[i].firstKeep));
            checkOutput($sformatf("vec%0d_last_keep", i), 64'(keepSeenQ[keepSeenQ.size()-1]), 64'(vecs[i].lastKeep));
         end
      end

      // len=16: beats on consecutive cycles, cmd ready again the cycle after
      // the second word is accepted.
      startTest();
      queueMessage(16'd16);
      n = 0;
      while (dataFireCount < 2 && n < 20) begin
         applyStimulus();
         n++;
      end
      applyStimulus();
      checkOutput("len16_cmd_ready_back", 64'(cmd_ready_o), 64'd1);
      drain(50);
      checkOutput("len16_beats", 64'(outCycQ.size()), 64'd2);
      if (outCycQ.size() == 2) begin
         checkOutput("len16_consecutive", 64'(outCycQ[1] - outCycQ[0]), 64'd1);
      end

      // len=0 is consumed silently, then len=8 gives a single full beat.
      startTest();
      queueMessage(16'd0);
      n = 0;
      while (cmdFireCount < 1 && n < 20) begin
         applyStimulus();
         n++;
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         checkOutput("len0_no_valid", 64'(valid_o), 64'd0);
         checkOutput("len0_idle", 64'(cmd_ready_o), 64'd1);
      end
      queueMessage(16'd8);
      drain(50);
      checkOutput("len0_then8_beats", 64'(keepSeenQ.size()), 64'd1);
      checkSeen("len0_then8", 0, 8'hFF, 1'b1);

      // len=20 with ready toggling every cycle: holds are checked every
      // stalled cycle inside applyStimulus.
      startTest();
      readyMode = 1;
      queueMessage(16'd20);
      drain(100);
      checkOutput("stall_beats", 64'(keepSeenQ.size()), 64'd3);
      checkSeen("stall_b0", 0, 8'hFF, 1'b0);
      checkSeen("stall_b1", 1, 8'hFF, 1'b0);
      checkSeen("stall_b2", 2, 8'h0F, 1'b1);
      readyMode = 0;

      // Back-to-back commands: the second length is taken while the first
      // message's last beat still sits in the output register.
      startTest();
      queueMessage(16'd5);
      queueMessage(16'd9);
      drain(100);
      checkOutput("b2b_cmds", 64'(cmdFireCount), 64'd2);
      checkOutput("b2b_pending_accept", 64'(cmdFirePending), 64'd1);
      checkOutput("b2b_beats", 64'(keepSeenQ.size()), 64'd3);
      checkSeen("b2b_b0", 0, 8'h1F, 1'b1);
      checkSeen("b2b_b1", 1, 8'hFF, 1'b0);
      checkSeen("b2b_b2", 2, 8'h01, 1'b1);

      // Reset in the middle of a 3-beat message.
      startTest();
      queueMessage(16'd20);
      n = 0;
      while (keepSeenQ.size() < 1 && n < 20) begin
         applyStimulus();
         n++;
      end
      nreset = 1'b0;
      cmdQ.delete();
      srcDataQ.delete();
      expBeatQ.delete();
      expDataQ.delete();
      prevStall = 1'b0;
      applyStimulus();
      checkOutput("midrst_valid", 64'(valid_o), 64'd0);
      checkOutput("midrst_keep", 64'(keep_o), 64'd0);
      checkOutput("midrst_last", 64'(last_o), 64'd0);
      checkOutput("midrst_cmd_ready", 64'(cmd_ready_o), 64'd0);
      nreset = 1'b1;
      applyStimulus();
      checkOutput("midrst_idle", 64'(cmd_ready_o), 64'd1);
      startTest();
      queueMessage(16'd8);
      drain(50);
      checkOutput("midrst_after_beats", 64'(keepSeenQ.size()), 64'd1);
      checkSeen("midrst_after", 0, 8'hFF, 1'b1);

      // Random lengths with random source gaps and downstream stalls.
      readyMode = 2;
      validMode = 1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) queueMessage(16'($urandom_range(0, 8)));
         else                           queueMessage(16'($urandom_range(1, 100)));
      end
      drain(20000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/len_keep_tx.md
Name: len_keep_tx

Overview:
- Transmit-side segmenter: takes one message byte length and a stream of D_W-byte data words, and emits beats with a thermometer byte-keep mask and a last flag.
- Mirror of the receive-side keep-mask-to-byte-count path: count in, thermometer mask out.
- Sits between the message builder and the MAC/UDP transmit stream.

Parameters:
- D_W, 8, bytes per data beat (power of 2, ≥2).
- LEN_W, 16, message length field width in bytes (MoldUDP64 message length).
- D_LW, 4, clog2(D_W)+1, width of the per-beat byte count.

Ports:
- clk  in  1  clock.
- nreset  in  1  synchronous active-low reset.
- cmd_valid_i  in  1  message length valid.
- cmd_len_i  in  LEN_W  message length in bytes.
- cmd_ready_o  out  1  length accepted when cmd_valid_i&cmd_ready_o.
- data_valid_i  in  1  input data word valid.
- data_i  in  8*D_W  data word, byte 0 in bits [7:0].
- data_ready_o  out  1  input word accepted when data_valid_i&data_ready_o.
- valid_o  out  1  output beat valid.
- data_o  out  8*D_W  output data word.
- keep_o  out  D_W  thermometer byte mask, bit i = byte i valid.
- last_o  out  1  final beat of message.
- ready_i  in  1  downstream ready.

Behaviour:
- Reset (nreset=0 at clk edge):
  - state=IDLE, rem=0.
  - valid_o=0, data_o=0, keep_o=0, last_o=0.
  - cmd_ready_o=0 and data_ready_o=0 while nreset=0.
- FSM IDLE:
  - cmd_ready_o=1.
  - On cmd handshake with cmd_len_i>0: rem<=cmd_len_i, go to STREAM.
  - cmd_len_i==0: command consumed, no beat produced, stay IDLE.
- FSM STREAM:
  - cmd_ready_o=0.
  - data_ready_o = (!valid_o | ready_i), i.e. the output register is free or draining this cycle.
- On a data handshake the output register loads on the next edge (latency 1 cycle, full throughput):
  - data_o<=data_i.
  - keep_o <= rem≥D_W ? all ones : thermo(rem), where thermo(n) = (1<<n)-1 (n low bits set). Bytes above keep in data_o are passed through unmodified.
  - last_o <= (rem≤D_W).
  - valid_o<=1.
  - rem <= rem-D_W, saturating at 0.
  - If last: state<=IDLE.
- Output hold: while valid_o=1 and ready_i=0, data_o/keep_o/last_o/valid_o are stable.
- valid_o clears after a ready_i handshake with no new load in the same cycle.
- Simultaneous events: drain and load in the same cycle is legal; no bubble.
- A new cmd may be accepted in IDLE while the previous last beat still waits in the output register.
- Beat count per message = ceil(len/D_W).
- Keep invariant: keep_o is always a thermometer (contiguous ones from bit 0), never 0 when valid_o=1.
  - The receive-side count of ones on keep_o equals min(rem,D_W) at load time.
- Width rules: rem is LEN_W bits; the compare against D_W is done in LEN_W bits; thermo input is rem[D_LW-1:0], only used when rem<D_W.
- Reset mid-message: everything is discarded. The upstream must re-issue the command; no partial-message recovery.
- data_valid_i in IDLE is ignored (data_ready_o=0).

Decomposition:
- Shared package holds:
  - FSM state enum {IDLE, STREAM}.
  - Default LEN_W/D_W constants used by the MoldUDP64 tx path.
- Sub-module thermo_from_cnt (combinational, params D_W, D_LW): cnt_i → mask_o = (1<<cnt_i)-1, cnt_i=D_W gives all ones.
  - Formal assert: $countones(mask_o)==cnt_i, and mask_o+1 is onehot.
- Top module holds the FSM, rem counter and output register.

Test Plan:
- len=16, D_W=8, data always valid, ready_i=1 → 2 beats on consecutive cycles, keep=0xFF/0xFF, last on 2nd; cmd_ready_o back to 1 the cycle after the 2nd data accept.
- len=13 → beats keep=0xFF then 0x1F, last=1 on 2nd; len=1 → single beat keep=0x01, last=1.
- len=0 → cmd accepted, no valid_o pulse, FSM stays IDLE; next cmd len=8 → one beat keep=0xFF last=1.
- len=20, ready_i toggled 0/1 every cycle → data_ready_o gated; outputs stable while stalled; 3 beats keep 0xFF,0xFF,0x0F, no data loss or duplication.
- Back-to-back cmds len=5 then len=9, ready_i=1 → beats keep 0x1F(last), 0xFF, 0x01(last); 2nd cmd accepted while the 1st last beat is still pending.
- nreset asserted mid-message (after 1 of 3 beats) → next cycle valid_o=0, keep_o=0, last_o=0, FSM IDLE; fresh cmd len=8 → correct single beat.
